griffin_li: RTL and testbench

- Computes the Griffin linear-form term l_i = (γ_i·y0 + y1 + x_i) mod p, where γ_i = i − 1.
- Feeds the per-lane nonlinear layer of the Griffin permutation, which computes y_i = x_i·(x_i² + α_i·l_i + β_i).
- Fully pipelined: accepts one operand set every cycle, result appears 2 cycles later.

---
 rtl/griffin_li_pkg.sv | 26 ++
 rtl/griffin_li_mod_add.sv | 41 ++++
 rtl/griffin_li.sv | 156 +++++++++++++++
 tb/tb_griffin_li.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/griffin_li_pkg.sv
// ---------------------------------------------------------------------------
// li_pkg
//
// Shared definitions for the Griffin linear-form block (griffin_li) and its
// modular adder. Holds the default field width and prime (BN254 scalar
// field), the field-element type and the width of the lane-derived
// multiplier gamma.
//
// Contents:
//   N_BITS         default width of a field element
//   PRIME_MODULUS  default field prime p
//   felem_t        one field element
//   GAMMA_W        width of the lane index and of gamma = i - 1
// ---------------------------------------------------------------------------
package li_pkg;

    localparam int N_BITS = 254;

    localparam logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    localparam int GAMMA_W = 5;

    typedef logic [N_BITS-1:0] felem_t;

endpackage : li_pkg

// File: rtl/griffin_li_mod_add.sv
// ---------------------------------------------------------------------------
// mod_add
//
// Combinational modular addition sum = (a + b) mod p for canonical operands
// (a, b < p). One adder one bit wider than the operands keeps the carry, and
// one conditional subtract of p brings the result back into [0, p). A sum
// exactly equal to p therefore reduces to 0.
//
// Ports:
//   a    in   N_BITS  first addend, canonical
//   b    in   N_BITS  second addend, canonical
//   sum  out  N_BITS  (a + b) mod p
// ---------------------------------------------------------------------------
module mod_add
    import li_pkg::*;
#(
    parameter int                N_BITS        = li_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = li_pkg::PRIME_MODULUS
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sum
);

    logic [N_BITS:0]   raw_sum;
    logic              needs_reduce;
    logic [N_BITS-1:0] subtrahend;

    // Widened add so the carry out of the top bit is never lost, then decide
    // whether one copy of p has to come off. Since both operands are below p
    // the raw sum is below 2p, so a single subtract is always enough. The
    // subtract is done on the low N_BITS only: the true difference is below
    // p < 2^N_BITS, so dropping the carry bit cannot change the result.
    always_comb begin
        raw_sum      = {1'b0, a} + {1'b0, b};
        needs_reduce = (raw_sum >= {1'b0, PRIME_MODULUS});
        subtrahend   = needs_reduce ? PRIME_MODULUS : '0;
        sum          = raw_sum[N_BITS-1:0] - subtrahend;
    end

endmodule : mod_add

// File: rtl/griffin_li.sv
// ---------------------------------------------------------------------------
// griffin_li
//
// Griffin linear-form term l_i = (gamma * y0 + y1 + x_i) mod p with
// gamma = i - 1 (gamma = 0 when i = 0). Feeds the per-lane nonlinear layer
// of the Griffin permutation. Fully pipelined with two register stages:
// one operand set is accepted every cycle and the result appears on l_i two
// clock edges after the inputs were applied. There is no handshake.
//
// Stage 1 registers t = gamma * y0 mod p (MSB-first double-and-add over the
// GAMMA_W bits of gamma) and s = (y1 + x_i) mod p. Stage 2 registers
// l_i = (t + s) mod p. Every addition goes through mod_add.
//
// Build option:
//   LI_INPUT_REDUCE_EN  when defined, y0, y1 and x_i each pass through one
//                       conditional subtract of p in front of stage 1, so any
//                       N_BITS value is accepted (2^254 < 2p). When not
//                       defined, inputs must already be canonical.
//
// Ports:
//   clk    in   1        clock, rising edge
//   rst_n  in   1        asynchronous active-low reset
//   i      in   GAMMA_W  lane index, gamma = i - 1
//   y0     in   N_BITS   first branch output, multiplied by gamma
//   y1     in   N_BITS   second branch output
//   x_i    in   N_BITS   lane input (previous-lane value)
//   l_i    out  N_BITS   (gamma * y0 + y1 + x_i) mod p, registered
// ---------------------------------------------------------------------------
module griffin_li
    import li_pkg::*;
#(
    parameter int                N_BITS        = li_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = li_pkg::PRIME_MODULUS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GAMMA_W-1:0] i,
    input  logic [N_BITS-1:0]  y0,
    input  logic [N_BITS-1:0]  y1,
    input  logic [N_BITS-1:0]  x_i,
    output logic [N_BITS-1:0]  l_i
);

    // Operands after the optional input reduction.
    logic [N_BITS-1:0] y0_c;
    logic [N_BITS-1:0] y1_c;
    logic [N_BITS-1:0] x_c;

    logic [GAMMA_W-1:0] gamma;

    // Double-and-add chain: acc[k] is the partial product after k bits of
    // gamma have been consumed, MSB first.
    logic [N_BITS-1:0] acc     [0:GAMMA_W];
    logic [N_BITS-1:0] dbl     [0:GAMMA_W-1];
    logic [N_BITS-1:0] dbl_add [0:GAMMA_W-1];

    logic [N_BITS-1:0] t_next;
    logic [N_BITS-1:0] s_next;
    logic [N_BITS-1:0] l_next;

    logic [N_BITS-1:0] t_q;
    logic [N_BITS-1:0] s_q;

`ifdef LI_INPUT_REDUCE_EN
    // Bring arbitrary N_BITS inputs into [0, p). One subtract is enough
    // because every N_BITS value is below 2p.
    always_comb begin
        y0_c = (y0  >= PRIME_MODULUS) ? (y0  - PRIME_MODULUS) : y0;
        y1_c = (y1  >= PRIME_MODULUS) ? (y1  - PRIME_MODULUS) : y1;
        x_c  = (x_i >= PRIME_MODULUS) ? (x_i - PRIME_MODULUS) : x_i;
    end
`else
    // Inputs are trusted to be canonical and go straight into the datapath.
    always_comb begin
        y0_c = y0;
        y1_c = y1;
        x_c  = x_i;
    end
`endif

    // Lane 0 must give gamma = 0 rather than the wrapped value 31, so the
    // decrement is suppressed there; lanes 1..31 map to 0..30.
    always_comb begin
        gamma = (i == '0) ? '0 : (i - GAMMA_W'(1));
    end

    assign acc[0] = '0;

    // Each step doubles the running product and, when the current gamma bit
    // is set, adds y0 on top. Both operations are modular adds, so the
    // partial product stays canonical all the way down the chain.
    for (genvar k = 0; k < GAMMA_W; k++) begin : g_chain
        mod_add #(
            .N_BITS        (N_BITS),
            .PRIME_MODULUS (PRIME_MODULUS)
        ) u_double (
            .a   (acc[k]),
            .b   (acc[k]),
            .sum (dbl[k])
        );

        mod_add #(
            .N_BITS        (N_BITS),
            .PRIME_MODULUS (PRIME_MODULUS)
        ) u_add_y0 (
            .a   (dbl[k]),
            .b   (y0_c),
            .sum (dbl_add[k])
        );

        assign acc[k+1] = gamma[GAMMA_W-1-k] ? dbl_add[k] : dbl[k];
    end

    assign t_next = acc[GAMMA_W];

    mod_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_add_branch (
        .a   (y1_c),
        .b   (x_c),
        .sum (s_next)
    );

    // Stage 1 capture of the two partial terms. Reset wipes any in-flight
    // operand set so nothing stale can reach the output after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
            s_q <= '0;
        end else begin
            t_q <= t_next;
            s_q <= s_next;
        end
    end

    mod_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_add_final (
        .a   (t_q),
        .b   (s_q),
        .sum (l_next)
    );

    // Stage 2 output register. Asynchronous reset forces l_i to zero at once,
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_i <= '0;
        end else begin
            l_i <= l_next;
        end
    end

endmodule : griffin_li

// File: tb/tb_griffin_li.sv
// ---------------------------------------------------------------------------
// tb_griffin_li
//
// Scoreboard bench for griffin_li. The driver applies an operand set on the
// falling edge and queues the expected l_i; a bench-side valid pipeline
// follows each set through the two register stages, and the monitor pops and
// compares on the falling edge where that set's result is on l_i. Expected
// values come from the directed constants or from a wide-integer reference
// model evaluating (gamma*y0 + y1 + x) mod p directly.
// Honours LI_INPUT_REDUCE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_griffin_li;
    import li_pkg::*;

    localparam felem_t P = PRIME_MODULUS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   i_in;
    felem_t       y0_in;
    felem_t       y1_in;
    felem_t       x_in;
    felem_t       l_out;

    felem_t       exp_q  [$];
    string        name_q [$];
    logic         in_valid = 1'b0;
    logic         v1;
    logic         v2;
    int           total = 0;
    int           bad   = 0;

    griffin_li dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i_in),
        .y0    (y0_in),
        .y1    (y1_in),
        .x_i   (x_in),
        .l_i   (l_out)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Bench-side copy of the pipeline depth: a set applied before edge k is
    // on l_i after edge k+1, and reset discards everything in flight.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
        end
    end

    // Reference model: plain wide-integer arithmetic, reducing every input
    // mod p first (a no-op for canonical inputs).
    function automatic felem_t model(input logic [4:0] idx, input felem_t a,
                                     input felem_t b, input felem_t c);
        logic [511:0] pp;
        logic [511:0] g;
        logic [511:0] r;
        pp = 512'(P);
        g  = (idx == 5'd0) ? 512'd0 : 512'(idx) - 512'd1;
        r  = (g * (512'(a) % pp) + 512'(b) % pp + 512'(c) % pp) % pp;
        return felem_t'(r);
    endfunction

    function automatic felem_t rand_fe();
        logic [255:0] r;
        r = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return felem_t'(r % 256'(P));
    endfunction

    task automatic checkOutput(input string name, input felem_t act, input felem_t expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [4:0] idx,
                                 input felem_t a, input felem_t b, input felem_t c,
                                 input felem_t expv);
        i_in     = idx;
        y0_in    = a;
        y1_in    = b;
        x_in     = c;
        in_valid = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(name);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 8 && exp_q.size() != 0; n++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Monitor: whenever the bench pipeline says a result is due, compare it
    // with the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && v2 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected: got %h with no result queued", l_out);
                end else begin
                    checkOutput(name_q.pop_front(), l_out, exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] idx;
        felem_t     a;
        felem_t     b;
        felem_t     c;

        rst_n = 1'b0;
        i_in  = 5'($urandom);
        y0_in = rand_fe();
        y1_in = rand_fe();
        x_in  = rand_fe();
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", l_out, '0);
        rst_n = 1'b1;

        // Directed cases.
        applyStimulus("basic",           5'd3,  felem_t'(5),      felem_t'(7), felem_t'(11), felem_t'(28));
        applyStimulus("gamma0_i1",       5'd1,  felem_t'('h1234), felem_t'(2), felem_t'(3),  felem_t'(5));
        applyStimulus("gamma0_i0",       5'd0,  felem_t'('h1234), felem_t'(2), felem_t'(3),  felem_t'(5));
        applyStimulus("wrap_zero",       5'd1,  '0,               P - 1,       felem_t'(1),  '0);
        applyStimulus("wrap_pm2",        5'd1,  '0,               P - 1,       P - 1,        P - 2);
        applyStimulus("max_gamma",       5'd31, P - 1,            '0,          '0,           P - 30);
        applyStimulus("max_gamma_small", 5'd31, felem_t'(2),      felem_t'(1), felem_t'(1),  felem_t'(62));
        drain();

        // Back-to-back throughput, then reset while a result is in flight.
        applyStimulus("thru_0", 5'd2, felem_t'(1), '0,          '0,          felem_t'(1));
        applyStimulus("thru_1", 5'd3, felem_t'(1), '0,          '0,          felem_t'(2));
        applyStimulus("thru_2", 5'd4, felem_t'(1), felem_t'(1), felem_t'(1), felem_t'(5));
        applyStimulus("thru_3", 5'd5, felem_t'(3), felem_t'(4), '0,          felem_t'(16));
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", l_out, '0);
        exp_q.delete();
        name_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_reset", 5'd6, felem_t'(10), felem_t'(1), felem_t'(2), felem_t'(53));
        drain();

`ifdef LI_INPUT_REDUCE_EN
        applyStimulus("reduce_inputs", 5'd2, P + 3, P, '0, felem_t'(3));
        applyStimulus("reduce_top",    5'd3, '1,    '1, '1, model(5'd3, '1, '1, '1));
        drain();
`endif

        // Randomised canonical vectors with occasional bubbles and
        // values near p.
        for (int n = 0; n < 200; n++) begin
            idx = 5'($urandom_range(0, 31));
            a   = rand_fe();
            b   = rand_fe();
            c   = rand_fe();
            if ($urandom_range(0, 7) == 0) a = P - 1 - felem_t'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = P - 1 - felem_t'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) c = P - 1 - felem_t'($urandom_range(0, 3));
`ifdef LI_INPUT_REDUCE_EN
            if ($urandom_range(0, 5) == 0) b = P + felem_t'($urandom_range(0, 1000));
`endif
            applyStimulus("random", idx, a, b, c, model(idx, a, b, c));
            if ($urandom_range(0, 5) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_griffin_li
